// File: rtl/adder_pkg.sv
// Shared definitions for approximate-adder accuracy monitors.
package adder_pkg;

    // Default operand width; the adder sum is one bit wider.
    localparam int WIDTH_DEFAULT = 8;
    // Default width of the sample window length and of the sample counters.
    localparam int CNT_W_DEFAULT = 16;
    // Default width of the summed error-distance accumulator.
    localparam int ACC_W_DEFAULT = 24;

    // Measurement window control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mon_state_t;

endpackage : adder_pkg

// File: rtl/adder_err_calc.sv
// Combinational error-distance unit: recomputes the exact sum X+Y+Cin and
// returns the unsigned distance between it and the sum the adder produced.
module adder_err_calc
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic [WIDTH:0]   sum,
    output logic [WIDTH:0]   err
);

    logic [WIDTH:0] exact;

    // The exact sum always fits in WIDTH+1 bits, so there is no carry loss.
    assign exact = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

    // Subtract the smaller from the larger so the distance never wraps.
    assign err = (sum >= exact) ? (sum - exact) : (exact - sum);

endmodule : adder_err_calc

// File: rtl/adder_error_monitor.sv
// Accuracy monitor for the approximate adder stage. Samples operand/sum
// tuples over a window of N samples and accumulates mismatch count, summed
// error distance (saturating), maximum error and sample count.
module adder_error_monitor
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic [WIDTH:0]   Sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [ACC_W-1:0] err_sum,
    output logic [WIDTH:0]   max_err
);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    mon_state_t       state_reg;
    mon_state_t       state_next;
    logic [CNT_W-1:0] n_reg;
    logic [CNT_W-1:0] accepted_reg;

    // Pipeline stage 1: captured tuple
    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_x_reg;
    logic [WIDTH-1:0] s1_y_reg;
    logic             s1_cin_reg;
    logic [WIDTH:0]   s1_sum_reg;

    // Pipeline stage 2: registered error distance
    logic             s2_valid_reg;
    logic [WIDTH:0]   s2_err_reg;
    logic [WIDTH:0]   s1_err;

    // Statistics
    logic [CNT_W-1:0] sample_cnt_reg;
    logic [CNT_W-1:0] mismatch_cnt_reg;
    logic [ACC_W-1:0] err_sum_reg;
    logic [ACC_W-1:0] err_sum_next;
    logic [ACC_W:0]   err_sum_wide;
    logic [WIDTH:0]   max_err_reg;

    logic             start_ok;
    logic             accept;
    logic             pipe_empty;

    // A start request only counts outside an active window.
    assign start_ok   = start && (state_reg != RUN);
    // Tuples are taken only while running and only up to the window length.
    assign accept     = (state_reg == RUN) && in_valid && (accepted_reg < n_reg);
    assign pipe_empty = !s1_valid_reg && !s2_valid_reg;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: a zero-length window completes immediately; a running
    // window completes once all N samples have drained through the pipeline.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if ((accepted_reg == n_reg) && pipe_empty) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Window length latch and accepted-sample counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            n_reg        <= '0;
            accepted_reg <= '0;
        end else if (start_ok) begin
            n_reg        <= num_samples;
            accepted_reg <= '0;
        end else if (accept) begin
            accepted_reg <= accepted_reg + CNT_W'(1);
        end
    end

    // Stage 1: capture the accepted tuple.
    always_ff @(posedge clock) begin
        if (reset || start_ok) begin
            s1_valid_reg <= 1'b0;
            s1_x_reg     <= '0;
            s1_y_reg     <= '0;
            s1_cin_reg   <= 1'b0;
            s1_sum_reg   <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_x_reg   <= X;
                s1_y_reg   <= Y;
                s1_cin_reg <= Cin;
                s1_sum_reg <= Sum;
            end
        end
    end

    adder_err_calc #(
        .WIDTH (WIDTH)
    ) u_err_calc (
        .x   (s1_x_reg),
        .y   (s1_y_reg),
        .cin (s1_cin_reg),
        .sum (s1_sum_reg),
        .err (s1_err)
    );

    // Stage 2: register the error distance of the captured tuple.
    always_ff @(posedge clock) begin
        if (reset || start_ok) begin
            s2_valid_reg <= 1'b0;
            s2_err_reg   <= '0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_err_reg <= s1_err;
            end
        end
    end

    // One extra bit catches accumulator overflow; clamp to all-ones if set.
    assign err_sum_wide = {1'b0, err_sum_reg} + {{(ACC_W - WIDTH){1'b0}}, s2_err_reg};
    assign err_sum_next = err_sum_wide[ACC_W] ? {ACC_W{1'b1}} : err_sum_wide[ACC_W-1:0];

    // Stage 3: fold each completed sample into the window statistics.
    always_ff @(posedge clock) begin
        if (reset || start_ok) begin
            sample_cnt_reg   <= '0;
            mismatch_cnt_reg <= '0;
            err_sum_reg      <= '0;
            max_err_reg      <= '0;
        end else if (s2_valid_reg) begin
            sample_cnt_reg <= sample_cnt_reg + CNT_W'(1);
            if (s2_err_reg != '0) begin
                mismatch_cnt_reg <= mismatch_cnt_reg + CNT_W'(1);
            end
            err_sum_reg <= err_sum_next;
            if (s2_err_reg > max_err_reg) begin
                max_err_reg <= s2_err_reg;
            end
        end
    end

    assign busy         = (state_reg == RUN);
    assign done         = (state_reg == DONE);
    assign sample_cnt   = sample_cnt_reg;
    assign mismatch_cnt = mismatch_cnt_reg;
    assign err_sum      = err_sum_reg;
    assign max_err      = max_err_reg;

endmodule : adder_error_monitor

// File: tb/tb_adder_error_monitor.sv
// Directed bench for adder_error_monitor: table-driven windows plus
// hand-written sequences for zero-length, ignored restart and reset cases.
module tb_adder_error_monitor;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] ty;
        logic       tcin;
        logic [8:0] tsum;
    } tup_t;

    typedef struct {
        int n;
        int first;
        int cnt;
        int exp_samp;
        int exp_mism;
        int exp_errsum;
        int exp_max;
        int exp_errsum_sat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_samples;
    logic        in_valid;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        cin;
    logic [8:0]  sum;

    logic        busy, done;
    logic [15:0] sample_cnt, mismatch_cnt;
    logic [23:0] err_sum;
    logic [8:0]  max_err;

    logic        busy_s, done_s;
    logic [15:0] sample_cnt_s, mismatch_cnt_s;
    logic [8:0]  err_sum_s;
    logic [8:0]  max_err_s;

    int vectors = 0;
    int miscompares = 0;

    tup_t tups [0:13];
    vec_t cases [0:3];

    always #5 clk = ~clk;

    adder_error_monitor dut (
        .clock        (clk),
        .reset        (reset),
        .start        (start),
        .num_samples  (num_samples),
        .in_valid     (in_valid),
        .X            (x),
        .Y            (y),
        .Cin          (cin),
        .Sum          (sum),
        .busy         (busy),
        .done         (done),
        .sample_cnt   (sample_cnt),
        .mismatch_cnt (mismatch_cnt),
        .err_sum      (err_sum),
        .max_err      (max_err)
    );

    adder_error_monitor #(.ACC_W(9)) dut_sat (
        .clock        (clk),
        .reset        (reset),
        .start        (start),
        .num_samples  (num_samples),
        .in_valid     (in_valid),
        .X            (x),
        .Y            (y),
        .Cin          (cin),
        .Sum          (sum),
        .busy         (busy_s),
        .done         (done_s),
        .sample_cnt   (sample_cnt_s),
        .mismatch_cnt (mismatch_cnt_s),
        .err_sum      (err_sum_s),
        .max_err      (max_err_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input tup_t t);
        in_valid = 1'b1;
        x        = t.tx;
        y        = t.ty;
        cin      = t.tcin;
        sum      = t.tsum;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        x        = 8'h00;
        y        = 8'h00;
        cin      = 1'b0;
        sum      = 9'h000;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        int i;
        i = 0;
        while (!done && i < max_cycles) begin
            tick();
            i++;
        end
        chk(name, done, 1);
    endtask

    task automatic chk_stats(input string tag, input int s, input int m, input int e, input int mx);
        chk({tag, "_sample_cnt"}, sample_cnt, s);
        chk({tag, "_mismatch_cnt"}, mismatch_cnt, m);
        chk({tag, "_err_sum"}, err_sum, e);
        chk({tag, "_max_err"}, max_err, mx);
    endtask

    task automatic run_case(input int i);
        tup_t bad;
        int   last;
        bad = '{8'h00, 8'h00, 1'b0, 9'h1FF};
        // Start edge carries a valid, erroneous tuple that must be dropped.
        start       = 1'b1;
        num_samples = 16'(cases[i].n);
        drive(bad);
        tick();
        start = 1'b0;
        idle_inputs();
        chk($sformatf("c%0d_busy_after_start", i), busy, 1);
        chk($sformatf("c%0d_cleared_samples", i), sample_cnt, 0);
        chk($sformatf("c%0d_cleared_err_sum", i), err_sum, 0);
        last = (cases[i].cnt > cases[i].n + 3) ? cases[i].cnt : cases[i].n + 3;
        for (int k = 0; k < last; k++) begin
            if (k < cases[i].cnt) drive(tups[cases[i].first + k]);
            else idle_inputs();
            tick();
            chk($sformatf("c%0d_done_k%0d", i, k), done, (k >= cases[i].n + 2) ? 1 : 0);
            chk($sformatf("c%0d_busy_k%0d", i, k), busy, (k >= cases[i].n + 2) ? 0 : 1);
        end
        idle_inputs();
        chk_stats($sformatf("c%0d", i), cases[i].exp_samp, cases[i].exp_mism,
                  cases[i].exp_errsum, cases[i].exp_max);
        chk($sformatf("c%0d_sat_err_sum", i), err_sum_s, cases[i].exp_errsum_sat);
        chk($sformatf("c%0d_sat_max_err", i), max_err_s, cases[i].exp_max);
        chk($sformatf("c%0d_sat_mismatch_cnt", i), mismatch_cnt_s, cases[i].exp_mism);
        $display("case %0d: n=%0d samples=%0d mismatches=%0d err_sum=%0d max_err=%0d sat_err_sum=%0d",
                 i, cases[i].n, sample_cnt, mismatch_cnt, err_sum, max_err, err_sum_s);
    endtask

    initial begin
        tups[0]  = '{8'hFF, 8'h01, 1'b0, 9'h100};
        tups[1]  = '{8'h11, 8'h11, 1'b0, 9'h022};
        tups[2]  = '{8'hFF, 8'h00, 1'b1, 9'h100};
        tups[3]  = '{8'hFF, 8'h01, 1'b0, 9'h0FF};
        tups[4]  = '{8'h11, 8'h11, 1'b0, 9'h030};
        tups[5]  = '{8'h01, 8'h02, 1'b0, 9'h003};
        tups[6]  = '{8'h10, 8'h10, 1'b1, 9'h025};
        for (int k = 7; k < 14; k++) tups[k] = '{8'h00, 8'h00, 1'b0, 9'h1FF};

        //            n first cnt samp mism errsum max sat
        cases[0] = '{3, 0,  3, 3, 0, 0,    0,   0};
        cases[1] = '{2, 3,  2, 2, 2, 15,   14,  15};
        cases[2] = '{2, 5,  5, 2, 1, 4,    4,   4};
        cases[3] = '{4, 10, 4, 4, 4, 2044, 511, 511};

        reset       = 1'b1;
        start       = 1'b0;
        num_samples = 16'd0;
        idle_inputs();
        tick();
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk_stats("reset", 0, 0, 0, 0);
        reset = 1'b0;

        // Tuples presented while IDLE are ignored.
        for (int k = 0; k < 3; k++) begin
            drive(tups[7]);
            tick();
        end
        idle_inputs();
        tick();
        tick();
        chk_stats("idle_drop", 0, 0, 0, 0);
        chk("idle_busy", busy, 0);
        $display("idle tuples: samples=%0d err_sum=%0d", sample_cnt, err_sum);

        for (int i = 0; i < 4; i++) begin
            run_case(i);
            if (i == 2) begin
                // Tuples presented while DONE are ignored and results hold.
                for (int k = 0; k < 3; k++) begin
                    drive(tups[7]);
                    tick();
                end
                idle_inputs();
                tick();
                tick();
                chk_stats("done_hold", 2, 1, 4, 4);
                chk("done_hold_done", done, 1);
                $display("done hold: samples=%0d err_sum=%0d", sample_cnt, err_sum);
            end
        end

        // Zero-length window: straight to DONE with cleared statistics.
        start       = 1'b1;
        num_samples = 16'd0;
        tick();
        start = 1'b0;
        chk("n0_done", done, 1);
        chk_stats("n0", 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("n0_busy_k%0d", k), busy, 0);
            tick();
        end
        $display("n0 window: done=%0d busy=%0d samples=%0d", done, busy, sample_cnt);

        // Start during RUN must have no effect on window or statistics.
        start       = 1'b1;
        num_samples = 16'd3;
        tick();
        start = 1'b0;
        drive(tups[3]);
        tick();
        drive(tups[4]);
        start       = 1'b1;
        num_samples = 16'd1;
        tick();
        start = 1'b0;
        chk("restart_busy", busy, 1);
        drive(tups[1]);
        tick();
        idle_inputs();
        wait_done("restart_done_seen", 20);
        chk_stats("restart", 3, 2, 15, 14);
        $display("ignored restart: samples=%0d mismatches=%0d err_sum=%0d", sample_cnt, mismatch_cnt, err_sum);

        // Reset with a sample in flight discards it and clears everything.
        start       = 1'b1;
        num_samples = 16'd4;
        tick();
        start = 1'b0;
        drive('{8'h00, 8'h00, 1'b0, 9'h005});
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk_stats("rst_mid", 0, 0, 0, 0);
        tick();
        tick();
        tick();
        chk_stats("rst_mid_later", 0, 0, 0, 0);
        start       = 1'b1;
        num_samples = 16'd1;
        tick();
        start = 1'b0;
        drive('{8'h01, 8'h01, 1'b0, 9'h003});
        tick();
        idle_inputs();
        wait_done("post_rst_done_seen", 20);
        chk_stats("post_rst", 1, 1, 1, 1);
        $display("post reset window: samples=%0d err_sum=%0d max_err=%0d", sample_cnt, err_sum, max_err);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_adder_error_monitor
